// File: rtl/systolic_tile_engine.sv
// Output-stationary GEMM tile engine: ROWS x COLS grid of MAC PEs with input skew,
// LOAD/FLUSH/DRAIN sequencing and ready/valid streaming on both sides.
module systolic_tile_engine #(
    parameter int ROWS     = 16,
    parameter int COLS     = 16,
    parameter int DATA_W_P = 8,
    parameter int ACC_W_P  = 32,
    parameter int K_MAX    = 256,
    localparam int KW      = $clog2(K_MAX + 1),
    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [KW-1:0]             k_len,
    output logic                      busy,
    output logic                      done,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ROWS*DATA_W_P-1:0]  a_vec,
    input  logic [COLS*DATA_W_P-1:0]  b_vec,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COLS*ACC_W_P-1:0]   c_row,
    output logic [RW-1:0]             c_row_idx
);

    localparam int FLUSH_N = ROWS + COLS - 2;
    localparam int FW      = (FLUSH_N > 1) ? $clog2(FLUSH_N) : 1;
    localparam int SKR     = (ROWS > 1) ? ROWS - 1 : 1;
    localparam int SKC     = (COLS > 1) ? COLS - 1 : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [KW-1:0]            k_len_q, k_len_d;
    logic [KW-1:0]            beat_cnt_q, beat_cnt_d;
    logic [FW-1:0]            flush_cnt_q, flush_cnt_d;
    logic [RW-1:0]            row_ptr_q, row_ptr_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic [COLS*ACC_W_P-1:0]  c_row_q, c_row_d;

    logic signed [DATA_W_P-1:0] sk_a_q [ROWS][SKR];
    logic signed [DATA_W_P-1:0] sk_a_d [ROWS][SKR];
    logic signed [DATA_W_P-1:0] sk_b_q [COLS][SKC];
    logic signed [DATA_W_P-1:0] sk_b_d [COLS][SKC];
    logic signed [DATA_W_P-1:0] fa_q   [ROWS][COLS];
    logic signed [DATA_W_P-1:0] fa_d   [ROWS][COLS];
    logic signed [DATA_W_P-1:0] fb_q   [ROWS][COLS];
    logic signed [DATA_W_P-1:0] fb_d   [ROWS][COLS];
    logic signed [ACC_W_P-1:0]  acc_q  [ROWS][COLS];
    logic signed [ACC_W_P-1:0]  acc_d  [ROWS][COLS];

    logic signed [DATA_W_P-1:0] a_src_s [ROWS];
    logic signed [DATA_W_P-1:0] b_src_s [COLS];
    logic signed [DATA_W_P-1:0] a_top_s [ROWS];
    logic signed [DATA_W_P-1:0] b_top_s [COLS];
    logic signed [DATA_W_P-1:0] a_in_s  [ROWS][COLS];
    logic signed [DATA_W_P-1:0] b_in_s  [ROWS][COLS];
    logic                       en_s;
    logic                       clr_s;

    // Full-precision signed product, sign-extended to the accumulator width.
    function automatic logic signed [ACC_W_P-1:0] mac_term(
        input logic signed [DATA_W_P-1:0] a,
        input logic signed [DATA_W_P-1:0] b
    );
        logic signed [2*DATA_W_P-1:0] prod;
        prod = $signed({{DATA_W_P{a[DATA_W_P-1]}}, a}) * $signed({{DATA_W_P{b[DATA_W_P-1]}}, b});
        return (ACC_W_P)'(prod);
    endfunction

    assign en_s  = ((state_q == ST_LOAD) && in_valid) || (state_q == ST_FLUSH);
    assign clr_s = (state_q == ST_IDLE) && start;

    // Control next-state: sequencing, counters, row pointer and status outputs.
    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        beat_cnt_d  = beat_cnt_q;
        flush_cnt_d = flush_cnt_q;
        row_ptr_d   = row_ptr_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    k_len_d     = k_len;
                    beat_cnt_d  = {KW{1'b0}};
                    flush_cnt_d = {FW{1'b0}};
                    row_ptr_d   = {RW{1'b0}};
                    if (k_len != {KW{1'b0}}) begin
                        state_d = ST_LOAD;
                    end else if (FLUSH_N == 0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    beat_cnt_d = beat_cnt_q + KW'(1);
                    if (beat_cnt_d == k_len_q) begin
                        state_d = (FLUSH_N == 0) ? ST_DRAIN : ST_FLUSH;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == FW'(FLUSH_N - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (row_ptr_q == RW'(ROWS - 1)) begin
                        state_d   = ST_IDLE;
                        row_ptr_d = {RW{1'b0}};
                        done_d    = 1'b1;
                    end else begin
                        row_ptr_d = row_ptr_q + RW'(1);
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d      = (state_d != ST_IDLE);
        in_ready_d  = (state_d == ST_LOAD);
        out_valid_d = (state_d == ST_DRAIN);
    end

    // Datapath next-state: operand injection, skew chains, PE forwarding and accumulation.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            a_src_s[i] = (state_q == ST_LOAD) ? a_vec[i*DATA_W_P +: DATA_W_P] : {DATA_W_P{1'b0}};
            a_top_s[i] = a_src_s[i];
        end
        for (int j = 0; j < COLS; j++) begin
            b_src_s[j] = (state_q == ST_LOAD) ? b_vec[j*DATA_W_P +: DATA_W_P] : {DATA_W_P{1'b0}};
            b_top_s[j] = b_src_s[j];
        end
        // Row i taps its chain after i stages; row/column 0 sees the input directly.
        for (int i = 1; i < ROWS; i++) begin
            a_top_s[i] = sk_a_q[i][i-1];
        end
        for (int j = 1; j < COLS; j++) begin
            b_top_s[j] = sk_b_q[j][j-1];
        end
        for (int i = 0; i < ROWS; i++) begin
            a_in_s[i][0] = a_top_s[i];
            for (int j = 1; j < COLS; j++) begin
                a_in_s[i][j] = fa_q[i][j-1];
            end
        end
        for (int j = 0; j < COLS; j++) begin
            b_in_s[0][j] = b_top_s[j];
            for (int i = 1; i < ROWS; i++) begin
                b_in_s[i][j] = fb_q[i-1][j];
            end
        end

        sk_a_d = sk_a_q;
        sk_b_d = sk_b_q;
        fa_d   = fa_q;
        fb_d   = fb_q;
        acc_d  = acc_q;
        if (clr_s) begin
            for (int i = 0; i < ROWS; i++) begin
                for (int s = 0; s < SKR; s++) sk_a_d[i][s] = {DATA_W_P{1'b0}};
            end
            for (int j = 0; j < COLS; j++) begin
                for (int s = 0; s < SKC; s++) sk_b_d[j][s] = {DATA_W_P{1'b0}};
            end
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    fa_d[i][j]  = {DATA_W_P{1'b0}};
                    fb_d[i][j]  = {DATA_W_P{1'b0}};
                    acc_d[i][j] = {ACC_W_P{1'b0}};
                end
            end
        end else if (en_s) begin
            for (int i = 0; i < ROWS; i++) begin
                sk_a_d[i][0] = a_src_s[i];
                for (int s = 1; s < SKR; s++) sk_a_d[i][s] = sk_a_q[i][s-1];
            end
            for (int j = 0; j < COLS; j++) begin
                sk_b_d[j][0] = b_src_s[j];
                for (int s = 1; s < SKC; s++) sk_b_d[j][s] = sk_b_q[j][s-1];
            end
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    fa_d[i][j]  = a_in_s[i][j];
                    fb_d[i][j]  = b_in_s[i][j];
                    acc_d[i][j] = acc_q[i][j] + mac_term(a_in_s[i][j], b_in_s[i][j]);
                end
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Presented row is taken from the post-update accumulators so it is valid on DRAIN entry.
    always_comb begin
        c_row_d = {(COLS*ACC_W_P){1'b0}};
        if (state_d == ST_DRAIN) begin
            for (int j = 0; j < COLS; j++) begin
                c_row_d[j*ACC_W_P +: ACC_W_P] = acc_d[row_ptr_d][j];
            end
        end else begin
            c_row_d = {(COLS*ACC_W_P){1'b0}};
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_len_q     <= {KW{1'b0}};
            beat_cnt_q  <= {KW{1'b0}};
            flush_cnt_q <= {FW{1'b0}};
            row_ptr_q   <= {RW{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            c_row_q     <= {(COLS*ACC_W_P){1'b0}};
            for (int i = 0; i < ROWS; i++) begin
                for (int s = 0; s < SKR; s++) sk_a_q[i][s] <= {DATA_W_P{1'b0}};
            end
            for (int j = 0; j < COLS; j++) begin
                for (int s = 0; s < SKC; s++) sk_b_q[j][s] <= {DATA_W_P{1'b0}};
            end
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    fa_q[i][j]  <= {DATA_W_P{1'b0}};
                    fb_q[i][j]  <= {DATA_W_P{1'b0}};
                    acc_q[i][j] <= {ACC_W_P{1'b0}};
                end
            end
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            beat_cnt_q  <= beat_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            row_ptr_q   <= row_ptr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            c_row_q     <= c_row_d;
            sk_a_q      <= sk_a_d;
            sk_b_q      <= sk_b_d;
            fa_q        <= fa_d;
            fb_q        <= fb_d;
            acc_q       <= acc_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign c_row     = c_row_q;
    assign c_row_idx = row_ptr_q;

endmodule

// File: tb/tb_systolic_tile_engine.sv
// Directed bench for systolic_tile_engine: a 2x2/ACC32 instance and a 4x4/ACC16 instance
// driven through shared stimulus, checked against hand-computed C tiles and cycle counts.
module tb_systolic_tile_engine;

    localparam int KW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start_s;
    logic          sel_s;
    logic [KW-1:0] k_len;
    logic          in_valid;
    logic          out_ready;
    logic [7:0]    cur_a [4];
    logic [7:0]    cur_b [4];

    logic          start_a, start_b;
    logic [15:0]   a_vec_a, b_vec_a;
    logic [31:0]   a_vec_b, b_vec_b;
    logic          busy_a, done_a, in_ready_a, out_valid_a;
    logic [63:0]   c_row_a;
    logic [0:0]    c_row_idx_a;
    logic          busy_b, done_b, in_ready_b, out_valid_b;
    logic [63:0]   c_row_b;
    logic [1:0]    c_row_idx_b;

    assign start_a = start_s & ~sel_s;
    assign start_b = start_s & sel_s;
    assign a_vec_a = {cur_a[1], cur_a[0]};
    assign b_vec_a = {cur_b[1], cur_b[0]};
    assign a_vec_b = {cur_a[3], cur_a[2], cur_a[1], cur_a[0]};
    assign b_vec_b = {cur_b[3], cur_b[2], cur_b[1], cur_b[0]};

    systolic_tile_engine #(.ROWS(2), .COLS(2), .DATA_W_P(8), .ACC_W_P(32), .K_MAX(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .k_len(k_len), .busy(busy_a), .done(done_a),
        .in_valid(in_valid), .in_ready(in_ready_a), .a_vec(a_vec_a), .b_vec(b_vec_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .c_row(c_row_a), .c_row_idx(c_row_idx_a)
    );

    systolic_tile_engine #(.ROWS(4), .COLS(4), .DATA_W_P(8), .ACC_W_P(16), .K_MAX(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .k_len(k_len), .busy(busy_b), .done(done_b),
        .in_valid(in_valid), .in_ready(in_ready_b), .a_vec(a_vec_b), .b_vec(b_vec_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .c_row(c_row_b), .c_row_idx(c_row_idx_b)
    );

    // Unified view of whichever instance is selected; 16-bit rows are read as signed.
    logic               v_busy, v_done, v_in_ready, v_out_valid;
    logic [1:0]         v_idx;
    logic signed [31:0] v_c [4];
    always_comb begin
        v_busy      = busy_a;
        v_done      = done_a;
        v_in_ready  = in_ready_a;
        v_out_valid = out_valid_a;
        v_idx       = {1'b0, c_row_idx_a};
        for (int i = 0; i < 4; i++) v_c[i] = 32'sd0;
        if (sel_s == 1'b0) begin
            for (int i = 0; i < 2; i++) v_c[i] = c_row_a[i*32 +: 32];
        end else begin
            v_busy      = busy_b;
            v_done      = done_b;
            v_in_ready  = in_ready_b;
            v_out_valid = out_valid_b;
            v_idx       = c_row_idx_b;
            for (int i = 0; i < 4; i++) v_c[i] = {{16{c_row_b[i*16+15]}}, c_row_b[i*16 +: 16]};
        end
    end

    int                 err_cnt = 0;
    int                 chk_cnt = 0;
    logic [7:0]         a_tab [8][4];
    logic [7:0]         b_tab [8][4];
    logic signed [31:0] exp_c [4][4];

    task automatic check_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_const(input logic [7:0] av, input logic [7:0] bv, input logic signed [31:0] cv);
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) begin
                a_tab[k][i] = av;
                b_tab[k][i] = bv;
            end
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) exp_c[i][j] = cv;
        end
    endtask

    // One full tile: vmode 1 stalls on odd cycles, rmode 1 applies the 1,0,0 out_ready pattern.
    task automatic run_tile(input bit sel_i, input int k, input int vmode, input int rmode,
                            input bit poke_start, input int exp_done, input int exp_load, input string tag);
        int n, beat, row, load_cyc, drain_cyc, cyc;
        bit seen_done;
        n = sel_i ? 4 : 2;
        beat = 0; row = 0; load_cyc = 0; drain_cyc = 0; seen_done = 1'b0;
        @(negedge clk);
        sel_s = sel_i; start_s = 1'b1; k_len = KW'(k); in_valid = 1'b0; out_ready = 1'b0;
        for (cyc = 1; cyc <= 60 && !seen_done; cyc++) begin
            @(negedge clk);
            start_s = poke_start && (cyc == 2);
            k_len   = (poke_start && cyc == 2) ? KW'(1) : KW'(k);
            if (v_in_ready) begin
                load_cyc++;
                if ((vmode == 0 || cyc % 2 == 0) && beat < k) begin
                    for (int i = 0; i < 4; i++) begin
                        cur_a[i] = a_tab[beat][i];
                        cur_b[i] = b_tab[beat][i];
                    end
                    in_valid = 1'b1;
                    beat++;
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        cur_a[i] = 8'($urandom);
                        cur_b[i] = 8'($urandom);
                    end
                    in_valid = 1'b0;
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    cur_a[i] = 8'($urandom);
                    cur_b[i] = 8'($urandom);
                end
                in_valid = 1'b1;
            end
            if (v_out_valid && row < n) begin
                check_eq({tag, "_row_idx"}, v_idx, row);
                for (int j = 0; j < n; j++) check_eq({tag, "_c_elem"}, v_c[j], exp_c[row][j]);
                out_ready = (rmode == 0) || (drain_cyc % 3 == 0);
                drain_cyc++;
                if (out_ready) row++;
            end else begin
                out_ready = 1'b0;
            end
            if (v_done) begin
                seen_done = 1'b1;
                check_eq({tag, "_done_cycle"}, cyc, exp_done);
                check_eq({tag, "_busy_at_done"}, v_busy, 0);
            end
        end
        check_eq({tag, "_done_seen"}, seen_done, 1);
        check_eq({tag, "_rows_out"}, row, n);
        check_eq({tag, "_load_cycles"}, load_cyc, exp_load);
        check_eq({tag, "_beats"}, beat, k);
        in_valid = 1'b0; out_ready = 1'b0; start_s = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, v_busy, 0);
        check_eq({tag, "_done"}, v_done, 0);
        check_eq({tag, "_in_ready"}, v_in_ready, 0);
        check_eq({tag, "_out_valid"}, v_out_valid, 0);
        check_eq({tag, "_idx"}, v_idx, 0);
        for (int j = 0; j < 4; j++) check_eq({tag, "_c"}, v_c[j], 0);
    endtask

    initial begin
        rst_n = 1'b0; start_s = 1'b0; sel_s = 1'b0; k_len = '0; in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cur_a[i] = 8'd0;
            cur_b[i] = 8'd0;
        end
        #23;
        check_idle_outputs("reset_a");
        sel_s = 1'b1; #1;
        check_idle_outputs("reset_b");
        @(negedge clk); rst_n = 1'b1;

        // 2x2 identity, with a start pulse during LOAD that must be ignored
        fill_const(8'd0, 8'd0, 32'sd0);
        a_tab[0] = '{8'd1, 8'd0, 8'd0, 8'd0}; b_tab[0] = '{8'd5, 8'd6, 8'd0, 8'd0};
        a_tab[1] = '{8'd0, 8'd1, 8'd0, 8'd0}; b_tab[1] = '{8'd7, 8'd8, 8'd0, 8'd0};
        exp_c[0][0] = 32'sd5; exp_c[0][1] = 32'sd6; exp_c[1][0] = 32'sd7; exp_c[1][1] = 32'sd8;
        run_tile(1'b0, 2, 0, 0, 1'b1, 7, 2, "ident");

        // Backpressure on DRAIN: rows held while out_ready low
        a_tab[0] = '{8'd1, 8'd2, 8'd0, 8'd0}; b_tab[0] = '{8'd5, 8'd6, 8'd0, 8'd0};
        a_tab[1] = '{8'd3, 8'd4, 8'd0, 8'd0}; b_tab[1] = '{8'd7, 8'd8, 8'd0, 8'd0};
        exp_c[0][0] = 32'sd26; exp_c[0][1] = 32'sd30; exp_c[1][0] = 32'sd38; exp_c[1][1] = 32'sd44;
        run_tile(1'b0, 2, 0, 1, 1'b0, 9, 2, "bp");

        // k_len = 0: accumulators from the previous tile must be cleared
        fill_const(8'd0, 8'd0, 32'sd0);
        run_tile(1'b0, 0, 0, 0, 1'b0, 5, 0, "k0");

        // 4x4 signed with input stalls: 3 * (-3 * 4) = -36
        fill_const(8'hFD, 8'd4, -32'sd36);
        run_tile(1'b1, 3, 1, 0, 1'b0, 17, 6, "stall");

        // 16-bit wrap: 3 * 16384 = 49152 reads back as -16384
        fill_const(8'h80, 8'h80, -32'sd16384);
        run_tile(1'b1, 3, 0, 0, 1'b0, 14, 3, "wrap");

        // Reset asserted mid-FLUSH on the 2x2 instance
        @(negedge clk);
        sel_s = 1'b0; start_s = 1'b1; k_len = KW'(2); in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cur_a[i] = 8'd9;
            cur_b[i] = 8'd9;
        end
        @(negedge clk); start_s = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("pre_rst_busy", v_busy, 1);
        check_eq("pre_rst_in_ready", v_in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_flush_rst");
        @(negedge clk); rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;

        fill_const(8'd0, 8'd0, 32'sd0);
        a_tab[0] = '{8'd2, 8'd3, 8'd0, 8'd0}; b_tab[0] = '{8'd4, 8'd5, 8'd0, 8'd0};
        exp_c[0][0] = 32'sd8; exp_c[0][1] = 32'sd10; exp_c[1][0] = 32'sd12; exp_c[1][1] = 32'sd15;
        run_tile(1'b0, 1, 0, 0, 1'b0, 6, 1, "post_rst");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
